target_cluster: RTL and testbench
=================================

# target_cluster

Downstream of the 10:1 frame down-sampler: consumes its 80-word frame bursts (bit 31 = detection flag, bits 30:0 = amplitude, non-detected bins arrive as 32'b0) and merges runs of adjacent flagged bins into clusters. Each cluster is emitted as one record (start bin, length, peak bin, peak amplitude) through a small FIFO with a valid/ready handshake toward the reporting/host side. A per-frame summary pulse reports the cluster count and overflow status.

## Interface
- FRAME_LEN, 80, valid words per frame; bin index = count of valid words since frame start.
- IDX_W, 7, width of bin index and cluster length (must hold FRAME_LEN).
- AMP_W, 31, amplitude width (data_in[AMP_W-1:0]).
- FIFO_DEPTH, 8, cluster record FIFO depth (power of two).

- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  32  bin word; [31] detection flag, [30:0] amplitude.
- valid_in  in  1  data_in qualifier; no backpressure, every valid word is consumed.
- cl_valid  out  1  a cluster record is present on cl_*.
- cl_ready  in  1  consumer accepts record when cl_valid & cl_ready.
- cl_start  out  IDX_W  first bin of cluster.
- cl_len  out  IDX_W  number of bins in cluster (1..FRAME_LEN).
- cl_peak_idx  out  IDX_W  bin of maximum amplitude in cluster.
- cl_peak_amp  out  AMP_W  maximum amplitude in cluster.
- frame_done  out  1  one-cycle pulse after last word of a frame.
- frame_clusters  out  IDX_W  clusters found in the frame just finished (incl. dropped); valid with frame_done, held until next pulse.
- overflow  out  1  sticky: a record was dropped because the FIFO was full; cleared only by rst.

## Operation
- Bin counter idx: increments on each valid_in, wraps FRAME_LEN-1 -> 0; idle cycles (valid_in=0) change nothing.
- Cluster tracker states: IDLE (no open cluster), OPEN (cluster in progress).
- IDLE, valid word, flag=1: open cluster; start=idx, len=1, peak_idx=idx, peak_amp=amp -> OPEN.
- OPEN, valid word, flag=1: len+1; replace peak only if amp strictly greater (ties keep lowest bin).
- OPEN, valid word, flag=0: close cluster (record excludes this word) -> IDLE.
- Word at idx=FRAME_LEN-1: if flag=1, it is included, then cluster closed; tracker always returns to IDLE; clusters never span frames.
- Close = push record {start, len, peak_idx, peak_amp} to FIFO and increment frame cluster counter.
- FIFO full at push and no pop that cycle: record dropped, overflow set; counter still increments. Full with simultaneous pop: push accepted.
- Flag=1 with zero amplitude is a valid detection. Flag=0 amplitude ignored.
- frame_clusters/frame_done driven from the edge sampling word FRAME_LEN-1; internal counter then zeroed (a cluster closed by that word is counted in that frame).
- rst mid-frame: idx=0, open cluster discarded, FIFO emptied, counters cleared; next valid word is bin 0.

## Timing
- Reset values: cl_valid=0, cl_start=0, cl_len=0, cl_peak_idx=0, cl_peak_amp=0, frame_done=0, frame_clusters=0, overflow=0.
- Push occurs on the edge that samples the closing word; FIFO is first-word-fall-through with registered head, so cl_valid is high in the cycle after that edge when FIFO was empty.
- Records leave in closing order (ascending cl_start). cl_* stable while cl_valid=1 and cl_ready=0.
- Pop on edge where cl_valid & cl_ready; next record (if any) presented the following cycle, allowing one record per cycle.
- frame_done high exactly one cycle, the cycle after word FRAME_LEN-1 sampled; back-to-back frames (80 contiguous valid cycles, then next frame immediately) fully supported.
- Sustained throughput: one input word per cycle.

## Test plan
- Single cluster: frame with flags at bins 10..12, amps 5,9,7, cl_ready=1 -> one record start=10, len=3, peak_idx=11, peak_amp=9, cl_valid the cycle after bin 13 sampled; frame_clusters=1.
- Edge bins and tie: flags at bins 0 and 78..79, amps at 78,79 both 4 -> records (0,1,0,amp0) then (78,2,78,4); second pushed on bin-79 edge; frame_done same cycle as its cl_valid; frame_clusters=2.
- Backpressure/overflow: alternating flags (40 single-bin clusters), cl_ready=0 -> 8 records held in order (start 0,2,..,14), overflow=1, frame_clusters=40; release cl_ready -> 8 pops on consecutive cycles.
- Full with simultaneous pop: FIFO full, cl_ready=1 on the cycle a cluster closes -> no drop, overflow stays 0.
- Gapped input: valid_in toggled randomly, all 80 bins flagged amp=bin -> one record (0,80,79,79); frame_done only after 80th valid word.
- Reset mid-frame: rst during open cluster at bin 30 -> all outputs at reset values; following full frame with flag at bin 5 reports start=5.

Source files
------------

// File: rtl/target_cluster_if.sv
// Bin-word input stream, cluster record handshake and per-frame summary for target_cluster.
// master = the side feeding bins and consuming records; slave = target_cluster itself.
interface target_cluster_if #(
   parameter int IDX_W = 7,
   parameter int AMP_W = 31
);
   logic [AMP_W:0]   data_in;
   logic             valid_in;
   logic             cl_valid;
   logic             cl_ready;
   logic [IDX_W-1:0] cl_start;
   logic [IDX_W-1:0] cl_len;
   logic [IDX_W-1:0] cl_peak_idx;
   logic [AMP_W-1:0] cl_peak_amp;
   logic             frame_done;
   logic [IDX_W-1:0] frame_clusters;
   logic             overflow;

   modport master (
      output data_in, valid_in, cl_ready,
      input  cl_valid, cl_start, cl_len, cl_peak_idx, cl_peak_amp,
             frame_done, frame_clusters, overflow
   );

   modport slave (
      input  data_in, valid_in, cl_ready,
      output cl_valid, cl_start, cl_len, cl_peak_idx, cl_peak_amp,
             frame_done, frame_clusters, overflow
   );
endinterface

// File: rtl/target_cluster.sv
// Merges runs of adjacent flagged bins within a frame into cluster records
// (start, length, peak bin, peak amplitude) and queues them in a small FWFT FIFO.
module target_cluster #(
   parameter int FRAME_LEN  = 80,
   parameter int IDX_W      = 7,
   parameter int AMP_W      = 31,
   parameter int FIFO_DEPTH = 8
) (
   input logic            clk,
   input logic            rst,
   target_cluster_if.slave bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int REC_W = 3 * IDX_W + AMP_W;

   typedef enum logic {IDLE, OPEN} state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q;
   logic [IDX_W-1:0]  start_q, start_d;
   logic [IDX_W-1:0]  len_q, len_d;
   logic [IDX_W-1:0]  pidx_q, pidx_d;
   logic [AMP_W-1:0]  pamp_q, pamp_d;
   logic [IDX_W-1:0]  cnt_q;
   logic [IDX_W-1:0]  frame_clusters_q;
   logic              frame_done_q;
   logic              overflow_q;

   logic [REC_W-1:0]  mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;

   logic              word_flag;
   logic [AMP_W-1:0]  word_amp;
   logic              last_bin;
   logic              close;
   logic [REC_W-1:0]  rec;
   logic              pop, full, push_ok, drop;

   assign word_flag = bus.data_in[AMP_W];
   assign word_amp  = bus.data_in[AMP_W-1:0];
   assign last_bin  = (idx_q == IDX_W'(FRAME_LEN - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         start_q <= '0;
         len_q   <= '0;
         pidx_q  <= '0;
         pamp_q  <= '0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         len_q   <= len_d;
         pidx_q  <= pidx_d;
         pamp_q  <= pamp_d;
      end
   end

   // The last bin of a frame is folded into the cluster first, so the record
   // for a run reaching the frame end is taken from the next-state values.
   always_comb begin
      state_d = state_q;
      start_d = start_q;
      len_d   = len_q;
      pidx_d  = pidx_q;
      pamp_d  = pamp_q;
      close   = 1'b0;
      rec     = {start_q, len_q, pidx_q, pamp_q};
      if (bus.valid_in) begin
         unique case (state_q)
            IDLE: begin
               if (word_flag) begin
                  start_d = idx_q;
                  len_d   = IDX_W'(1);
                  pidx_d  = idx_q;
                  pamp_d  = word_amp;
                  state_d = OPEN;
               end
            end
            OPEN: begin
               if (word_flag) begin
                  len_d = len_q + IDX_W'(1);
                  if (word_amp > pamp_q) begin
                     pidx_d = idx_q;
                     pamp_d = word_amp;
                  end
               end else begin
                  close   = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
         if (last_bin) begin
            if (word_flag) begin
               close = 1'b1;
               rec   = {start_d, len_d, pidx_d, pamp_d};
            end
            state_d = IDLE;
         end
      end
   end

   assign pop     = bus.cl_valid & bus.cl_ready;
   assign full    = (count_q == CNT_W'(FIFO_DEPTH));
   assign push_ok = close & (~full | pop);
   assign drop    = close & full & ~pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= rec;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         unique case ({push_ok, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q            <= '0;
         cnt_q            <= '0;
         frame_clusters_q <= '0;
         frame_done_q     <= 1'b0;
         overflow_q       <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         overflow_q   <= overflow_q | drop;
         if (bus.valid_in) begin
            if (last_bin) begin
               idx_q            <= '0;
               frame_clusters_q <= cnt_q + IDX_W'(close);
               cnt_q            <= '0;
               frame_done_q     <= 1'b1;
            end else begin
               idx_q <= idx_q + IDX_W'(1);
               cnt_q <= cnt_q + IDX_W'(close);
            end
         end
      end
   end

   assign bus.cl_valid = (count_q != '0);
   assign {bus.cl_start, bus.cl_len, bus.cl_peak_idx, bus.cl_peak_amp} = mem_q[rd_ptr_q];
   assign bus.frame_done     = frame_done_q;
   assign bus.frame_clusters = frame_clusters_q;
   assign bus.overflow       = overflow_q;

endmodule

// File: tb/tb_target_cluster.sv
// Scenario bench for target_cluster: expected records come from scanning each frame
// table and are queued up front, then compared in order as the DUT hands them out.
module tb_target_cluster;
   typedef struct packed {
      logic [6:0]  start;
      logic [6:0]  len;
      logic [6:0]  pidx;
      logic [30:0] pamp;
   } rec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   rec_t exp_q[$];
   bit          fr_flag [80];
   logic [30:0] fr_amp  [80];

   target_cluster_if #(.IDX_W(7), .AMP_W(31)) bus ();

   target_cluster #(.FRAME_LEN(80), .IDX_W(7), .AMP_W(31), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;

   // Record scoreboard: every accepted handshake must match the oldest expectation.
   always @(negedge clk) begin
      rec_t got, e;
      if (!rst && bus.cl_valid && bus.cl_ready) begin
         got = {bus.cl_start, bus.cl_len, bus.cl_peak_idx, bus.cl_peak_amp};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_record: got start=%0d len=%0d pidx=%0d pamp=%0d, expected no record",
                     got.start, got.len, got.pidx, got.pamp);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               n_fail++;
               $display("FAIL record: got start=%0d len=%0d pidx=%0d pamp=%0d, expected start=%0d len=%0d pidx=%0d pamp=%0d",
                        got.start, got.len, got.pidx, got.pamp, e.start, e.len, e.pidx, e.pamp);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic clear_frame();
      for (int b = 0; b < 80; b++) begin
         fr_flag[b] = 1'b0;
         fr_amp[b]  = '0;
      end
   endtask

   task automatic scan_frame(input int max_push, output int ncl);
      bit   open;
      int   pushed;
      rec_t cur;
      open = 1'b0; pushed = 0; ncl = 0; cur = '0;
      for (int b = 0; b < 80; b++) begin
         if (fr_flag[b]) begin
            if (!open) begin
               open = 1'b1;
               cur.start = 7'(b); cur.len = 7'd1; cur.pidx = 7'(b); cur.pamp = fr_amp[b];
            end else begin
               cur.len = cur.len + 7'd1;
               if (fr_amp[b] > cur.pamp) begin
                  cur.pidx = 7'(b); cur.pamp = fr_amp[b];
               end
            end
         end
         if (open && (!fr_flag[b] || b == 79)) begin
            open = 1'b0;
            ncl++;
            if (pushed < max_push) begin
               exp_q.push_back(cur);
               pushed++;
            end
         end
      end
   endtask

   // Each word is sampled on the next rising edge; returns 1 time unit after it.
   task automatic drive_bins(input int from, input int to, input bit gaps);
      for (int b = from; b <= to; b++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               bus.valid_in = 1'b0;
               bus.data_in  = $urandom;
               @(posedge clk); #1;
            end
         end
         bus.data_in  = {fr_flag[b], fr_flag[b] ? fr_amp[b] : 31'($urandom)};
         bus.valid_in = 1'b1;
         @(posedge clk); #1;
      end
      bus.valid_in = 1'b0;
      bus.data_in  = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic drain_queue(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if (exp_q.size() !== 0) begin
         n_fail++;
         $display("FAIL %s_drain: got %0d records outstanding, expected 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      bus.valid_in = 1'b0; bus.data_in = '0; bus.cl_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (bus.cl_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cl_valid: got %b expected 0", bus.cl_valid); end
      n_checks++; if (bus.cl_start !== 7'd0) begin n_fail++; $display("FAIL reset_cl_start: got %0d expected 0", bus.cl_start); end
      n_checks++; if (bus.cl_len !== 7'd0) begin n_fail++; $display("FAIL reset_cl_len: got %0d expected 0", bus.cl_len); end
      n_checks++; if (bus.cl_peak_idx !== 7'd0) begin n_fail++; $display("FAIL reset_cl_peak_idx: got %0d expected 0", bus.cl_peak_idx); end
      n_checks++; if (bus.cl_peak_amp !== 31'd0) begin n_fail++; $display("FAIL reset_cl_peak_amp: got %0d expected 0", bus.cl_peak_amp); end
      n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done); end
      n_checks++; if (bus.frame_clusters !== 7'd0) begin n_fail++; $display("FAIL reset_frame_clusters: got %0d expected 0", bus.frame_clusters); end
      n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", bus.overflow); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_cluster();
      int ncl;
      clear_frame();
      fr_flag[10] = 1; fr_amp[10] = 31'd5;
      fr_flag[11] = 1; fr_amp[11] = 31'd9;
      fr_flag[12] = 1; fr_amp[12] = 31'd7;
      scan_frame(100, ncl);
      bus.cl_ready = 1'b1;
      drive_bins(0, 12, 1'b0);
      n_checks++; if (bus.cl_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early: got %b expected 0", bus.cl_valid); end
      drive_bins(13, 13, 1'b0);
      n_checks++; if (bus.cl_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_latency: got %b expected 1", bus.cl_valid); end
      drive_bins(14, 79, 1'b0);
      n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL single_frame_done: got %b expected 1", bus.frame_done); end
      n_checks++; if (bus.frame_clusters !== 7'(ncl)) begin n_fail++; $display("FAIL single_frame_clusters: got %0d expected %0d", bus.frame_clusters, ncl); end
      @(posedge clk); #1;
      n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL single_frame_done_pulse: got %b expected 0", bus.frame_done); end
      drain_queue("single");
   endtask

   task automatic test_edge_tie();
      int ncl;
      clear_frame();
      fr_flag[0]  = 1; fr_amp[0]  = 31'h1234;
      fr_flag[78] = 1; fr_amp[78] = 31'd4;
      fr_flag[79] = 1; fr_amp[79] = 31'd4;
      scan_frame(100, ncl);
      bus.cl_ready = 1'b1;
      drive_bins(0, 78, 1'b0);
      n_checks++; if (bus.cl_valid !== 1'b0) begin n_fail++; $display("FAIL edge_valid_before_last: got %b expected 0", bus.cl_valid); end
      drive_bins(79, 79, 1'b0);
      n_checks++; if (bus.cl_valid !== 1'b1) begin n_fail++; $display("FAIL edge_valid_last: got %b expected 1", bus.cl_valid); end
      n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL edge_frame_done: got %b expected 1", bus.frame_done); end
      n_checks++; if (bus.frame_clusters !== 7'd2) begin n_fail++; $display("FAIL edge_frame_clusters: got %0d expected 2", bus.frame_clusters); end
      drain_queue("edge");
   endtask

   task automatic test_overflow();
      int ncl;
      clear_frame();
      for (int b = 0; b < 80; b += 2) begin
         fr_flag[b] = 1; fr_amp[b] = 31'(b + 1);
      end
      scan_frame(8, ncl);
      bus.cl_ready = 1'b0;
      drive_bins(0, 79, 1'b0);
      n_checks++; if (bus.frame_clusters !== 7'd40) begin n_fail++; $display("FAIL ovf_frame_clusters: got %0d expected 40", bus.frame_clusters); end
      n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", bus.overflow); end
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (bus.cl_start !== 7'd0 || bus.cl_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_head_held: got valid=%b start=%0d expected valid=1 start=0", bus.cl_valid, bus.cl_start); end
      bus.cl_ready = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      n_checks++; if (bus.cl_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_eight_pops: got valid=%b after 8 cycles expected 0", bus.cl_valid); end
      n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", bus.overflow); end
      drain_queue("ovf");
   endtask

   task automatic test_reset_mid();
      int ncl;
      clear_frame();
      fr_flag[3] = 1; fr_amp[3] = 31'd11;
      fr_flag[4] = 1; fr_amp[4] = 31'd12;
      for (int b = 25; b <= 40; b++) begin
         fr_flag[b] = 1; fr_amp[b] = 31'(b);
      end
      bus.cl_ready = 1'b0;
      drive_bins(0, 30, 1'b0);
      n_checks++; if (bus.cl_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b expected 1", bus.cl_valid); end
      rst = 1'b1;
      #2;
      n_checks++; if (bus.cl_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_cl_valid: got %b expected 0", bus.cl_valid); end
      n_checks++; if ({bus.cl_start, bus.cl_len, bus.cl_peak_idx, bus.cl_peak_amp} !== 52'd0) begin n_fail++; $display("FAIL rmid_cl_fields: got start=%0d len=%0d pidx=%0d pamp=%0d expected all 0", bus.cl_start, bus.cl_len, bus.cl_peak_idx, bus.cl_peak_amp); end
      n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rmid_overflow: got %b expected 0", bus.overflow); end
      n_checks++; if (bus.frame_clusters !== 7'd0) begin n_fail++; $display("FAIL rmid_frame_clusters: got %0d expected 0", bus.frame_clusters); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      clear_frame();
      fr_flag[5] = 1; fr_amp[5] = 31'd77;
      scan_frame(100, ncl);
      bus.cl_ready = 1'b1;
      drive_bins(0, 79, 1'b0);
      n_checks++; if (bus.frame_clusters !== 7'd1) begin n_fail++; $display("FAIL rmid_next_frame_clusters: got %0d expected 1", bus.frame_clusters); end
      drain_queue("rmid");
   endtask

   task automatic test_full_pop();
      int ncl;
      do_reset();
      clear_frame();
      for (int b = 0; b <= 16; b += 2) begin
         fr_flag[b] = 1; fr_amp[b] = 31'(100 + b);
      end
      scan_frame(100, ncl);
      bus.cl_ready = 1'b0;
      drive_bins(0, 16, 1'b0);
      n_checks++; if (bus.cl_valid !== 1'b1 || bus.cl_start !== 7'd0) begin n_fail++; $display("FAIL fullpop_head: got valid=%b start=%0d expected valid=1 start=0", bus.cl_valid, bus.cl_start); end
      bus.cl_ready = 1'b1;
      drive_bins(17, 17, 1'b0);
      n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow: got %b expected 0", bus.overflow); end
      drive_bins(18, 79, 1'b0);
      n_checks++; if (bus.frame_clusters !== 7'd9) begin n_fail++; $display("FAIL fullpop_frame_clusters: got %0d expected 9", bus.frame_clusters); end
      n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL fullpop_overflow_end: got %b expected 0", bus.overflow); end
      drain_queue("fullpop");
   endtask

   task automatic test_gapped();
      int ncl;
      clear_frame();
      for (int b = 0; b < 80; b++) begin
         fr_flag[b] = 1; fr_amp[b] = 31'(b);
      end
      scan_frame(100, ncl);
      bus.cl_ready = 1'b1;
      drive_bins(0, 78, 1'b1);
      n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL gap_frame_done_early: got %b expected 0", bus.frame_done); end
      n_checks++; if (bus.cl_valid !== 1'b0) begin n_fail++; $display("FAIL gap_valid_early: got %b expected 0", bus.cl_valid); end
      drive_bins(79, 79, 1'b1);
      n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL gap_frame_done: got %b expected 1", bus.frame_done); end
      n_checks++; if (bus.frame_clusters !== 7'd1) begin n_fail++; $display("FAIL gap_frame_clusters: got %0d expected 1", bus.frame_clusters); end
      drain_queue("gap");
   endtask

   task automatic test_back_to_back();
      int ncl_a, ncl_b;
      bus.cl_ready = 1'b1;
      for (int b = 0; b < 80; b++) begin
         fr_flag[b] = 1'($urandom_range(0, 1)); fr_amp[b] = 31'($urandom_range(0, 15));
      end
      scan_frame(100, ncl_a);
      drive_bins(0, 79, 1'b0);
      n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_a: got %b expected 1", bus.frame_done); end
      n_checks++; if (bus.frame_clusters !== 7'(ncl_a)) begin n_fail++; $display("FAIL b2b_clusters_a: got %0d expected %0d", bus.frame_clusters, ncl_a); end
      for (int b = 0; b < 80; b++) begin
         fr_flag[b] = 1'($urandom_range(0, 1)); fr_amp[b] = 31'($urandom_range(0, 15));
      end
      scan_frame(100, ncl_b);
      drive_bins(0, 0, 1'b0);
      n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse: got %b expected 0", bus.frame_done); end
      drive_bins(1, 79, 1'b0);
      n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done_b: got %b expected 1", bus.frame_done); end
      n_checks++; if (bus.frame_clusters !== 7'(ncl_b)) begin n_fail++; $display("FAIL b2b_clusters_b: got %0d expected %0d", bus.frame_clusters, ncl_b); end
      drain_queue("b2b");
   endtask

   initial begin
      test_reset();
      test_single_cluster();
      test_edge_tie();
      test_overflow();
      test_reset_mid();
      test_full_pop();
      test_gapped();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
